// File: rtl/id_pkg.sv
// Shared class codes, one-hot bit positions and decoded-entry metadata
// for the instruction-decode pipeline stage.
package id_pkg;

    localparam logic [7:0] CLS_LOAD  = 8'd0;
    localparam logic [7:0] CLS_STORE = 8'd1;
    localparam logic [7:0] CLS_ARITH = 8'd2;
    localparam logic [7:0] CLS_IMM   = 8'd3;
    localparam logic [7:0] CLS_JUMP  = 8'd4;
    localparam logic [7:0] CLS_JCOND = 8'd5;

    localparam int CB_LOAD  = 0;
    localparam int CB_STORE = 1;
    localparam int CB_ARITH = 2;
    localparam int CB_IMM   = 3;
    localparam int CB_JUMP  = 4;
    localparam int CB_JCOND = 5;

    typedef logic [5:0] id_cls_t;

    typedef struct packed {
        id_cls_t cls;
        logic    illegal;
    } id_meta_t;

    function automatic id_cls_t cls_onehot(input logic [7:0] code);
        id_cls_t oh;
        oh = '0;
        case (code)
            CLS_LOAD:  oh[CB_LOAD]  = 1'b1;
            CLS_STORE: oh[CB_STORE] = 1'b1;
            CLS_ARITH: oh[CB_ARITH] = 1'b1;
            CLS_IMM:   oh[CB_IMM]   = 1'b1;
            CLS_JUMP:  oh[CB_JUMP]  = 1'b1;
            CLS_JCOND: oh[CB_JCOND] = 1'b1;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Pure combinational field extractor for one instruction word.
// ID_ILLEGAL_TRAP_EN enables the illegal-class flag.
module id_field_decode
    import id_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 5,
    parameter int CLASS_W = 3,
    parameter int REG_AW  = 3,
    parameter int ADDR_W  = 5
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OPC_W-1:0]   o_opcode,
    output logic [REG_AW-1:0]  o_rd,
    output logic [REG_AW-1:0]  o_rs2,
    output logic [REG_AW-1:0]  o_rs1,
    output logic [ADDR_W-1:0]  o_addr,
    output id_meta_t           o_meta
);

    localparam int RD_HI = INSTR_W - OPC_W - 1;

    logic [7:0] w_code;

    assign w_code   = 8'(i_instr[INSTR_W-1 -: CLASS_W]);
    assign o_opcode = i_instr[INSTR_W-1 -: OPC_W];
    assign o_rd     = i_instr[RD_HI -: REG_AW];
    assign o_rs2    = i_instr[RD_HI-REG_AW -: REG_AW];
    assign o_rs1    = i_instr[REG_AW+1:2];
    assign o_addr   = i_instr[ADDR_W-1:0];

    assign o_meta.cls = cls_onehot(w_code);
`ifdef ID_ILLEGAL_TRAP_EN
    assign o_meta.illegal = (w_code > CLS_JCOND);
`else
    assign o_meta.illegal = 1'b0;
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage with a 2-entry skid buffer and accept counter.
// ID_ILLEGAL_TRAP_EN adds the illegal flag and err_sticky output.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 5,
    parameter int CLASS_W = 3,
    parameter int REG_AW  = 3,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs2,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [ADDR_W-1:0]  out_address,
    output logic [5:0]         out_class,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   accept_cnt
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic               err_sticky
`endif
);

    if ((OPC_W + 2*REG_AW + 2 > INSTR_W) || (ADDR_W > INSTR_W - OPC_W)
        || (CLASS_W > OPC_W)) begin : g_bad_params
        $error("id_stage_pipe: illegal parameter combination");
    end

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rs1;
        logic [ADDR_W-1:0] addr;
        id_meta_t          meta;
    } dec_t;

    dec_t             w_dec;
    dec_t             r_main;
    dec_t             r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire;
    logic             w_out_fire;

    id_field_decode #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .CLASS_W (CLASS_W),
        .REG_AW  (REG_AW),
        .ADDR_W  (ADDR_W)
    ) u_dec (
        .i_instr  (in_instr),
        .o_opcode (w_dec.opcode),
        .o_rd     (w_dec.rd),
        .o_rs2    (w_dec.rs2),
        .o_rs1    (w_dec.rs1),
        .o_addr   (w_dec.addr),
        .o_meta   (w_dec.meta)
    );

    // in_ready comes straight from the skid flag, never from out_ready
    assign in_ready   = !r_skid_valid;
    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_out_fire = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_cnt        <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_out_fire) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_main <= w_dec;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                if (!r_main_valid) begin
                    r_main       <= w_dec;
                    r_main_valid <= 1'b1;
                end else begin
                    r_skid       <= w_dec;
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!flush && w_out_fire && r_main.meta.illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err_sticky = r_err;
`endif

    assign out_valid   = r_main_valid;
    assign out_opcode  = r_main.opcode;
    assign out_rd      = r_main.rd;
    assign out_rs2     = r_main.rs2;
    assign out_rs1     = r_main.rs1;
    assign out_address = r_main.addr;
    assign out_class   = r_main.meta.cls;
    assign out_illegal = r_main.meta.illegal;
    assign accept_cnt  = r_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomised bench for id_stage_pipe against a 2-deep FIFO reference model.
// Build with ID_ILLEGAL_TRAP_EN to also cover the illegal-class trap.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_rs2;
    logic [2:0]  out_rs1;
    logic [4:0]  out_address;
    logic [5:0]  out_class;
    logic        out_illegal;
    logic [15:0] accept_cnt;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        err_sticky;
`endif

    id_stage_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs2     (out_rs2),
        .out_rs1     (out_rs1),
        .out_address (out_address),
        .out_class   (out_class),
        .out_illegal (out_illegal),
        .accept_cnt  (accept_cnt)
`ifdef ID_ILLEGAL_TRAP_EN
        ,
        .err_sticky  (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] q[$];
    int unsigned m_cnt = 0;
    bit          m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_cls(input logic [15:0] w);
        int code;
        code = int'(w) / 8192;
        return (code < 6) ? (32'd1 << code) : 32'd0;
    endfunction

    function automatic logic ref_ill(input logic [15:0] w);
`ifdef ID_ILLEGAL_TRAP_EN
        return (int'(w) / 8192) >= 6;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_out();
        logic [15:0] w;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("accept_cnt", accept_cnt, m_cnt % 65536);
        if (q.size() > 0) begin
            w = q[0];
            chk("opcode", out_opcode, (w >> 11) & 31);
            chk("rd", out_rd, (w >> 8) & 7);
            chk("rs2", out_rs2, (w >> 5) & 7);
            chk("rs1", out_rs1, (w >> 2) & 7);
            chk("address", out_address, w & 31);
            chk("class", out_class, ref_cls(w));
            chk("illegal", out_illegal, ref_ill(w));
        end
`ifdef ID_ILLEGAL_TRAP_EN
        chk("err_sticky", err_sticky, m_err);
`endif
    endtask

    task automatic cycle(input bit iv, input logic [15:0] ins,
                         input bit ordy, input bit fl);
        bit inf;
        bit outf;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        inf  = iv && (q.size() < 2);
        outf = ordy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (outf) begin
                if (ref_ill(q[0])) m_err = 1;
                void'(q.pop_front());
            end
            if (inf) begin
                q.push_back(ins);
                m_cnt++;
            end
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'(($urandom));
        out_ready = 1'($urandom);
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        m_cnt = 0;
        m_err = 0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", accept_cnt, 0);
        chk("rst_opcode", out_opcode, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_rs2", out_rs2, 0);
        chk("rst_rs1", out_rs1, 0);
        chk("rst_addr", out_address, 0);
        chk("rst_class", out_class, 0);
        chk("rst_illegal", out_illegal, 0);
`ifdef ID_ILLEGAL_TRAP_EN
        chk("rst_err", err_sticky, 0);
`endif
    endtask

    initial begin
        int unsigned snap;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        cycle(1, 16'h4A9C, 1, 0);
        chk("dec_valid", out_valid, 1);
        chk("dec_opcode", out_opcode, 5'h09);
        chk("dec_rd", out_rd, 2);
        chk("dec_rs2", out_rs2, 4);
        chk("dec_rs1", out_rs1, 7);
        chk("dec_addr", out_address, 5'h1C);
        chk("dec_class", out_class, 6'b000100);
        cycle(0, 16'h0, 1, 0);

        cycle(1, 16'h1234, 0, 0);
        cycle(1, 16'h2345, 0, 0);
        chk("bp_full", in_ready, 0);
        cycle(1, 16'h3456, 0, 0);
        chk("bp_hold", out_opcode, 5'h02);
        repeat (3) cycle(0, 16'h0, 1, 0);

        cycle(1, 16'h8421, 0, 0);
        cycle(1, 16'hA5A5, 0, 0);
        snap = m_cnt;
        cycle(1, 16'h7777, 0, 1);
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_cnt", accept_cnt, snap);

`ifdef ID_ILLEGAL_TRAP_EN
        cycle(1, 16'hC000, 0, 0);
        chk("ill_flag", out_illegal, 1);
        chk("ill_class", out_class, 0);
        chk("ill_err0", err_sticky, 0);
        cycle(0, 16'h0, 1, 0);
        chk("ill_err1", err_sticky, 1);
        repeat (3) cycle(0, 16'h0, 1, 0);
        chk("ill_hold", err_sticky, 1);
        do_reset();
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle(($urandom % 4) != 0, 16'($urandom),
                  ($urandom % 3) != 0, ($urandom % 40) == 0);
        end

        do_reset();
        for (int i = 0; i < 65536 + 3; i++) begin
            cycle(1, 16'($urandom), 1, 0);
        end
        chk("wrap_cnt", accept_cnt, 3);
        cycle(0, 16'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
